// File: rtl/sprite_pkg.sv
`default_nettype none
// ==========================================================================
// Module : sprite_pkg
// Desc   : Shared sprite constants, orientation codes and renderer FSM states
// Rev    : 1.0  initial release
// ==========================================================================
package sprite_pkg;

   localparam int SPRITE_W = 8;

   typedef enum logic [1:0] {
      ORIENT_UP    = 2'd0,
      ORIENT_RIGHT = 2'd1,
      ORIENT_DOWN  = 2'd2,
      ORIENT_LEFT  = 2'd3
   } orient_t;

   localparam logic [3:0] c_SPR_HEART         = 4'd0;
   localparam logic [3:0] c_SPR_PLAYER_IDLE_1 = 4'd1;
   localparam logic [3:0] c_SPR_PLAYER_IDLE_2 = 4'd2;
   localparam logic [3:0] c_SPR_PLAYER_WALK_1 = 4'd3;
   localparam logic [3:0] c_SPR_PLAYER_WALK_2 = 4'd4;
   localparam logic [3:0] c_SPR_WOLF_1        = 4'd5;
   localparam logic [3:0] c_SPR_WOLF_2        = 4'd6;
   localparam logic [3:0] c_SPR_SHEEP_IDLE_1  = 4'd7;
   localparam logic [3:0] c_SPR_SHEEP_IDLE_2  = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_line_renderer_if.sv
`default_nettype none
// ==========================================================================
// Module : sprite_line_renderer_if
// Desc   : Sprite ROM read bus between the line renderer and the sprite ROM
// Rev    : 1.0  initial release
// ==========================================================================
interface sprite_line_renderer_if;
   import sprite_pkg::*;

   logic       rom_read_enable;
   logic [3:0] rom_sprite_ID;
   orient_t    rom_orientation;
   logic [2:0] rom_line_index;
   logic [7:0] rom_data;

   modport master (
      output rom_read_enable,
      output rom_sprite_ID,
      output rom_orientation,
      output rom_line_index,
      input  rom_data
   );

   modport slave (
      input  rom_read_enable,
      input  rom_sprite_ID,
      input  rom_orientation,
      input  rom_line_index,
      output rom_data
   );
endinterface
`default_nettype wire

// File: rtl/sprite_slot_hit.sv
`default_nettype none
// ==========================================================================
// Module : sprite_slot_hit
// Desc   : Horizontal range compare and scaled column select for one slot
// Rev    : 1.0  initial release
// ==========================================================================
module sprite_slot_hit
   import sprite_pkg::*;
#(
   parameter int SCALE_LOG2 = 3
) (
   input  logic [9:0]          hpos,
   input  logic [9:0]          x_pos,
   input  logic                hit,
   input  logic [SPRITE_W-1:0] line,
   output logic                lit
);
   localparam logic [9:0] c_FOOT = 10'(SPRITE_W << SCALE_LOG2);

   logic [9:0] w_dx;
   logic [2:0] w_col;

   // Wrapping subtract: pixels left of x_pos land far above c_FOOT.
   assign w_dx  = hpos - x_pos;
   assign w_col = w_dx[SCALE_LOG2 +: 3];
   assign lit   = hit && (w_dx < c_FOOT) && line[w_col];
endmodule
`default_nettype wire

// File: rtl/sprite_line_renderer.sv
`default_nettype none
// ==========================================================================
// Module : sprite_line_renderer
// Desc   : Fetches next-line sprite rows in hblank, scales them in active
//          video. Optional overlap flag built when SPRITE_COLLISION_EN set.
// Rev    : 1.0  initial release
// ==========================================================================
module sprite_line_renderer
   import sprite_pkg::*;
#(
   parameter int NUM_SLOTS  = 4,
   parameter int SCALE_LOG2 = 3,
   parameter int H_ACTIVE   = 640,
   parameter int V_TOTAL    = 525
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [9:0]              hpos,
   input  logic [9:0]              vpos,
   input  logic [NUM_SLOTS-1:0]    slot_valid,
   input  logic [4*NUM_SLOTS-1:0]  slot_id,
   input  logic [2*NUM_SLOTS-1:0]  slot_orient,
   input  logic [10*NUM_SLOTS-1:0] slot_x,
   input  logic [10*NUM_SLOTS-1:0] slot_y,
   sprite_line_renderer_if.master  rom,
   output logic                    pixel_on,
   output logic [2:0]              pixel_slot,
   output logic                    collision
);
   localparam logic [9:0] c_FOOT      = 10'(SPRITE_W << SCALE_LOG2);
   localparam logic [9:0] c_H_ACTIVE  = 10'(H_ACTIVE);
   localparam logic [9:0] c_V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [2:0] c_LAST_SLOT = 3'(NUM_SLOTS - 1);

   fsm_state_t r_state, w_state_nxt;

   logic [2:0]          r_slot;
   logic                r_cap_pend;
   logic [2:0]          r_cap_idx;
   logic [NUM_SLOTS-1:0] r_hit;
   logic [9:0]          r_x        [NUM_SLOTS];
   logic [SPRITE_W-1:0] r_line_buf [NUM_SLOTS];

   logic       w_issue;
   logic [9:0] w_nline, w_dy, w_sel_x, w_sel_y;
   logic [3:0] w_sel_id;
   logic [1:0] w_sel_or;
   logic       w_sel_valid, w_sel_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // hpos is only looked at from IDLE, so a stray hblank mid-fetch is ignored.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (hpos == c_H_ACTIVE)     w_state_nxt = ST_FETCH;
         ST_FETCH: if (r_slot == c_LAST_SLOT)  w_state_nxt = ST_DRAIN;
         ST_DRAIN:                             w_state_nxt = ST_IDLE;
         default:                              w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_issue = (r_state == ST_FETCH);

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_id    = '0;
      w_sel_or    = '0;
      w_sel_x     = '0;
      w_sel_y     = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (r_slot == 3'(i)) begin
            w_sel_valid = slot_valid[i];
            w_sel_id    = slot_id[4*i +: 4];
            w_sel_or    = slot_orient[2*i +: 2];
            w_sel_x     = slot_x[10*i +: 10];
            w_sel_y     = slot_y[10*i +: 10];
         end
      end
   end

   assign w_nline   = (vpos == c_V_LAST) ? 10'd0 : vpos + 10'd1;
   assign w_dy      = w_nline - w_sel_y;
   assign w_sel_hit = w_sel_valid && (w_dy < c_FOOT);

   // Issue slot k while capturing the ROM reply for slot k-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_slot              <= '0;
         r_cap_pend          <= 1'b0;
         r_cap_idx           <= '0;
         r_hit               <= '0;
         rom.rom_read_enable <= 1'b0;
         rom.rom_sprite_ID   <= '0;
         rom.rom_orientation <= ORIENT_UP;
         rom.rom_line_index  <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_x[i]        <= '0;
            r_line_buf[i] <= '0;
         end
      end else begin
         r_cap_pend          <= w_issue;
         r_cap_idx           <= r_slot;
         rom.rom_read_enable <= w_issue && w_sel_hit;
         if (w_issue) begin
            r_slot <= (r_slot == c_LAST_SLOT) ? 3'd0 : r_slot + 3'd1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
               if (r_slot == 3'(i)) begin
                  r_x[i]   <= w_sel_x;
                  r_hit[i] <= w_sel_hit;
               end
            end
            if (w_sel_hit) begin
               rom.rom_sprite_ID   <= w_sel_id;
               rom.rom_orientation <= orient_t'(w_sel_or);
               rom.rom_line_index  <= w_dy[SCALE_LOG2 +: 3];
            end
         end
         if (r_cap_pend) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
               if (r_cap_idx == 3'(i))
                  r_line_buf[i] <= rom.rom_read_enable ? ~rom.rom_data : '0;
            end
         end
      end
   end

   logic                 w_active;
   logic [NUM_SLOTS-1:0] w_lit;
   logic [2:0]           w_win;

   assign w_active = (hpos < c_H_ACTIVE);

   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         sprite_slot_hit #(
            .SCALE_LOG2 (SCALE_LOG2)
         ) u_slot_hit (
            .hpos  (hpos),
            .x_pos (r_x[gi]),
            .hit   (r_hit[gi] & w_active),
            .line  (r_line_buf[gi]),
            .lit   (w_lit[gi])
         );
      end
   endgenerate

   always_comb begin
      w_win = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (w_lit[i]) w_win = 3'(i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pixel_on   <= 1'b0;
         pixel_slot <= '0;
      end else begin
         pixel_on   <= |w_lit;
         pixel_slot <= w_win;
      end
   end

`ifdef SPRITE_COLLISION_EN
   logic w_multi;
   logic r_collision;

   // Clearing the lowest set bit leaves something only if two or more are lit.
   assign w_multi = |(w_lit & (w_lit - NUM_SLOTS'(1)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             r_collision <= 1'b0;
      else if (w_multi)                       r_collision <= 1'b1;
      else if (hpos == 10'd0 && vpos == 10'd0) r_collision <= 1'b0;
   end

   assign collision = r_collision;
`else
   assign collision = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_renderer.sv
`default_nettype none
// ==========================================================================
// Module : tb_sprite_line_renderer
// Desc   : Scoreboard bench for sprite_line_renderer with a behavioural ROM
// Rev    : 1.0  initial release
// ==========================================================================
module tb_sprite_line_renderer;
   import sprite_pkg::*;

   localparam int NUM_SLOTS  = 4;
   localparam int SCALE_LOG2 = 3;
   localparam int H_ACTIVE   = 640;
   localparam int V_TOTAL    = 525;
   localparam int H_TOTAL    = 800;
   localparam int FOOT       = 8 << SCALE_LOG2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [9:0]              hpos = '0;
   logic [9:0]              vpos = '0;
   logic [NUM_SLOTS-1:0]    slot_valid  = '0;
   logic [4*NUM_SLOTS-1:0]  slot_id     = '0;
   logic [2*NUM_SLOTS-1:0]  slot_orient = '0;
   logic [10*NUM_SLOTS-1:0] slot_x      = '0;
   logic [10*NUM_SLOTS-1:0] slot_y      = '0;
   logic       pixel_on;
   logic [2:0] pixel_slot;
   logic       collision;

   sprite_line_renderer_if rom ();

   sprite_line_renderer #(
      .NUM_SLOTS  (NUM_SLOTS),
      .SCALE_LOG2 (SCALE_LOG2),
      .H_ACTIVE   (H_ACTIVE),
      .V_TOTAL    (V_TOTAL)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .hpos        (hpos),
      .vpos        (vpos),
      .slot_valid  (slot_valid),
      .slot_id     (slot_id),
      .slot_orient (slot_orient),
      .slot_x      (slot_x),
      .slot_y      (slot_y),
      .rom         (rom),
      .pixel_on    (pixel_on),
      .pixel_slot  (pixel_slot),
      .collision   (collision)
   );

   always #5 clk = ~clk;

   // Behavioural sprite ROM, active-low rows.
   function automatic logic [7:0] rom_fn(input logic [3:0] id, input logic [1:0] ori,
                                         input logic [2:0] li);
      if (id == 4'd0 && ori == 2'd0 && li == 3'd0) return 8'b11000111;
      if (id[0]) return 8'h00;
      return 8'h5A ^ {li, ori, id[2:0]};
   endfunction

   always_comb rom.rom_data = rom_fn(rom.rom_sprite_ID, rom.rom_orientation, rom.rom_line_index);

   typedef struct {
      logic       on;
      logic [2:0] slot;
      logic       col;
      int         h;
      int         v;
   } pix_t;

   pix_t       pq[$];
   logic [8:0] rq[$];
   int n_checks = 0;
   int n_errors = 0;

   logic       m_hit [NUM_SLOTS];
   logic [9:0] m_x   [NUM_SLOTS];
   logic [7:0] m_buf [NUM_SLOTS];
   logic       m_col;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m_hit[i] = 1'b0;
         m_x[i]   = '0;
         m_buf[i] = '0;
      end
      m_col = 1'b0;
   endtask

   task automatic model_fetch(input logic [9:0] v);
      logic [9:0] nl, dy;
      logic [3:0] id;
      logic [1:0] ori;
      logic [2:0] li;
      nl = (int'(v) == V_TOTAL - 1) ? 10'd0 : v + 10'd1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         id       = slot_id[4*i +: 4];
         ori      = slot_orient[2*i +: 2];
         dy       = nl - slot_y[10*i +: 10];
         li       = 3'(dy >> SCALE_LOG2);
         m_x[i]   = slot_x[10*i +: 10];
         m_hit[i] = slot_valid[i] && (int'(dy) < FOOT);
         if (m_hit[i]) begin
            m_buf[i] = ~rom_fn(id, ori, li);
            rq.push_back({id, ori, li});
         end else begin
            m_buf[i] = '0;
         end
      end
   endtask

   function automatic pix_t model_pixel(input logic [9:0] h, input logic [9:0] v);
      pix_t e;
      int nlit;
      logic [9:0] dx;
      e.on = 1'b0; e.slot = '0; e.h = int'(h); e.v = int'(v); nlit = 0;
      if (int'(h) < H_ACTIVE) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            dx = h - m_x[i];
            if (m_hit[i] && int'(dx) < FOOT && m_buf[i][dx >> SCALE_LOG2]) begin
               if (!e.on) begin
                  e.on   = 1'b1;
                  e.slot = 3'(i);
               end
               nlit++;
            end
         end
      end
`ifdef SPRITE_COLLISION_EN
      if (nlit >= 2) m_col = 1'b1;
      else if (h == 10'd0 && v == 10'd0) m_col = 1'b0;
      e.col = m_col;
`else
      e.col = 1'b0;
`endif
      return e;
   endfunction

   task automatic sample();
      pix_t e;
      logic [8:0] r;
      if (pq.size() > 0) begin
         e = pq.pop_front();
         check_eq($sformatf("pixel_on h%0d v%0d", e.h, e.v), 32'(pixel_on), 32'(e.on));
         check_eq($sformatf("pixel_slot h%0d v%0d", e.h, e.v), 32'(pixel_slot), 32'(e.slot));
         check_eq($sformatf("collision h%0d v%0d", e.h, e.v), 32'(collision), 32'(e.col));
      end
      if (rq.size() == 0) begin
         check_eq("rom_idle", 32'(rom.rom_read_enable), 32'd0);
      end else if (rom.rom_read_enable) begin
         r = rq.pop_front();
         check_eq("rom_request",
                  32'({rom.rom_sprite_ID, rom.rom_orientation, rom.rom_line_index}), 32'(r));
      end
   endtask

   task automatic step(input int h, input int v);
      @(posedge clk);
      #1;
      sample();
      hpos = 10'(h);
      vpos = 10'(v);
      if (h == H_ACTIVE) model_fetch(10'(v));
      pq.push_back(model_pixel(10'(h), 10'(v)));
   endtask

   task automatic run_line(input int v);
      for (int h = 0; h < H_TOTAL; h++) step(h, v);
      check_eq($sformatf("rom_reads_done v%0d", v), 32'(rq.size()), 32'd0);
   endtask

   task automatic set_slot(input int i, input logic v, input logic [3:0] id,
                           input logic [1:0] ori, input int x, input int y);
      slot_valid[i]          = v;
      slot_id[4*i +: 4]      = id;
      slot_orient[2*i +: 2]  = ori;
      slot_x[10*i +: 10]     = 10'(x);
      slot_y[10*i +: 10]     = 10'(y);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_rom_re"},    32'(rom.rom_read_enable), 32'd0);
      check_eq({tag, "_rom_id"},    32'(rom.rom_sprite_ID), 32'd0);
      check_eq({tag, "_rom_line"},  32'(rom.rom_line_index), 32'd0);
      check_eq({tag, "_pixel_on"},  32'(pixel_on), 32'd0);
      check_eq({tag, "_pixel_slot"},32'(pixel_slot), 32'd0);
      check_eq({tag, "_collision"}, 32'(collision), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Reset asserted just after slot 1 has been issued.
      set_slot(0, 1'b1, 4'd1, 2'd0, 200, 101);
      set_slot(1, 1'b1, 4'd5, 2'd1, 260, 93);
      for (int h = 0; h <= 643; h++) step(h, 100);
      check_eq("pre_reset_rom_re", 32'(rom.rom_read_enable), 32'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      pq.delete();
      rq.delete();
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int h = 644; h < H_TOTAL; h++) step(h, 100);
      run_line(101);
      run_line(102);

      // Heart row at x=100.
      slot_valid = '0;
      set_slot(0, 1'b1, c_SPR_HEART, 2'd0, 100, 51);
      run_line(50);
      run_line(51);

      // Slot below the next line: no fetch, no pixels.
      set_slot(0, 1'b1, c_SPR_HEART, 2'd0, 100, 200);
      run_line(50);
      run_line(51);

      // Overlapping slots 0 and 2.
      slot_valid = '0;
      set_slot(0, 1'b1, 4'd1, 2'd0, 290, 60);
      set_slot(2, 1'b1, 4'd3, 2'd2, 300, 60);
      run_line(59);
      run_line(60);
      run_line(61);

      // Right-edge clipping.
      slot_valid = '0;
      set_slot(0, 1'b1, 4'd1, 2'd0, 600, 70);
      run_line(69);
      run_line(70);

      // Vertical wrap into line 0 of the next frame.
      slot_valid = '0;
      set_slot(1, 1'b1, 4'd4, 2'd3, 20, 0);
      run_line(524);
      run_line(0);

      @(posedge clk);
      #1;
      sample();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
Downstream consumer of the sprite ROM. It sits between the VGA sync counters and the pixel colour mux.
- During each horizontal blanking interval it fetches, for up to NUM_SLOTS entities, the ROM line needed on the next scanline. The results go into a per-slot line buffer.
- During active video it scales the buffered lines and outputs a registered per-pixel "sprite on" flag plus the index of the winning slot.

Parameters:
NUM_SLOTS, 4, number of entity slots (1..8).
SCALE_LOG2, 3, log2 of screen pixels per sprite pixel; sprite footprint is (8<<SCALE_LOG2) square.
H_ACTIVE, 640, first hblank hpos; fetch starts here.
V_TOTAL, 525, lines per frame; vpos wraps from V_TOTAL-1 to 0.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
hpos  in  10  current horizontal pixel counter
vpos  in  10  current line counter
slot_valid  in  NUM_SLOTS  slot enable, one bit per slot
slot_id  in  4*NUM_SLOTS  sprite ID per slot (slot i = bits [4i+3:4i])
slot_orient  in  2*NUM_SLOTS  orientation per slot: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT
slot_x  in  10*NUM_SLOTS  top-left x, screen pixels
slot_y  in  10*NUM_SLOTS  top-left y, screen pixels
rom_read_enable  out  1  ROM read strobe
rom_sprite_ID  out  4  ROM sprite select
rom_orientation  out  2  ROM orientation select
rom_line_index  out  3  ROM line select
rom_data  in  8  ROM line; valid the cycle after the read; active-low; bit c = column c (0 = leftmost)
pixel_on  out  1  a sprite pixel is lit at the registered hpos
pixel_slot  out  3  winning slot index (0 when pixel_on = 0)
collision  out  1  sticky overlap flag (see Optional Feature)

Behaviour:
- Reset (async, active-low): FSM to IDLE; all outputs 0; line_buf, latched x and hit flags cleared.
- Next line: nline = (vpos == V_TOTAL-1) ? 0 : vpos+1.
- Per-slot row: dy = nline - slot_y, 10-bit unsigned. The slot hits when slot_valid and dy < (8<<SCALE_LOG2). line_index = dy >> SCALE_LOG2.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH when hpos == H_ACTIVE.
  - FETCH handles slot k = 0..NUM_SLOTS-1, one per cycle:
    - Latch slot_x[k] and the hit flag.
    - If the slot hits: rom_read_enable = 1 with that slot's id, orientation and line_index.
    - If it misses: rom_read_enable = 0 and the slot's buffer is cleared.
  - After the last slot, FETCH -> DRAIN.
  - Pipelined capture: the cycle after issuing slot k, line_buf[k] <= ~rom_data, only if slot k hit.
  - DRAIN captures the final slot, then goes to IDLE.
  - Total fetch time is NUM_SLOTS+1 cycles, and must finish before hpos wraps to 0.
- ROM outputs are registered. When not issuing: rom_read_enable = 0; the id, orientation and line-index outputs hold their last value.
- Slot inputs are sampled only in FETCH. Changes at other times take effect on the next scanline.
- Display, computed in one cycle and registered (latency 1 from hpos):
  - dx = hpos - x_latched[i]. Slot i is lit if hit_i, hpos < H_ACTIVE, dx < (8<<SCALE_LOG2) and line_buf[i][dx>>SCALE_LOG2].
  - The lowest lit slot index wins and drives pixel_slot.
  - For hpos >= H_ACTIVE: pixel_on = 0 and pixel_slot = 0.
- Boundaries:
  - Sprites whose x extends past H_ACTIVE are clipped.
  - y near V_TOTAL-1 plus wrap: the 10-bit compare handles it; no partial-frame reuse.
  - hblank starting again mid-FETCH (illegal timing) is ignored; the FSM ignores hpos until IDLE.
  - Reset mid-FETCH clears everything; the following line shows no sprites.

Optional Feature:
Macro SPRITE_COLLISION_EN.
- Defined: collision sets (registered) when two or more slots are lit at the same active hpos. It stays set until the cycle where hpos == 0 and vpos == 0, when it clears. Set wins on the same cycle.
- Undefined: collision is tied to 0 and no overlap logic is built.

Decomposition:
- sprite_pkg holds:
  - orientation codes UP/RIGHT/DOWN/LEFT and sprite ID constants (0 Heart … 8 Sheep_Idle_2);
  - SPRITE_W = 8;
  - FSM state encoding.
- One sub-module, sprite_slot_hit: combinational range compare plus bit select per slot, instantiated NUM_SLOTS times for the display path.

Test Plan:
- Reset asserted mid-FETCH (slot 1 issued) -> all outputs 0 immediately, FSM IDLE, no pixel_on on the next line.
- Slot 0 valid, id 0 (Heart), UP, x=100, y=51, vpos=50, hpos reaches 640 -> rom_read_enable at cycle 0 with line_index 0. On line 51, rom_data 8'b11000111 lights hpos 100..123 off, 124..147 on.
- Slot 0 valid but y=200, vpos=50 -> no ROM read for slot 0, pixel_on stays 0 for the whole next line.
- Slots 0 and 2 overlap at hpos 300 -> pixel_slot = 0. With SPRITE_COLLISION_EN, collision = 1 and held until the (0,0) position.
- slot_x = 600, SCALE_LOG2 = 3, all-on row -> pixel_on for hpos 600..639 only, 0 at 640+.
- vpos = 524, slot_y = 0 -> fetch uses nline 0, line_index 0; sprite appears on line 0 of the next frame.
